// File: rtl/ieee754_op_front_pkg.sv
// ieee754_pkg: shared op encodings, operand classes, constants and flag indices
package ieee754_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int FLG_INV = 3;
  localparam int FLG_DBZ = 2;
  localparam int FLG_BYP = 1;
  localparam int FLG_DEN = 0;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;
endpackage

// File: rtl/ieee754_op_front_if.sv
// ieee754_op_front_if: request and response valid/ready channels
interface ieee754_op_front_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  modport master (output in_valid, in_a, in_b, in_op, out_ready,
                  input in_ready, out_valid, out_result, out_flags);
  modport slave (input in_valid, in_a, in_b, in_op, out_ready,
                 output in_ready, out_valid, out_result, out_flags);
endinterface

// File: rtl/ieee754_op_front_classify.sv
// ieee754_classify: flush denormals to signed zero and classify the operand
module ieee754_classify
  import ieee754_pkg::*;
(
  input  logic [31:0] x,
  output cls_e        cls,
  output logic [31:0] y,
  output logic        den
);
  assign den = x[30:23] == 8'h00 && x[22:0] != '0;
  assign y = den ? {x[31], 31'b0} : x;
  assign cls = x[30:23] == EXP_MAX ? (x[22:0] != '0 ? CLS_NAN : CLS_INF) :
               x[30:23] == 8'h00 ? CLS_ZERO : CLS_NORM;
endmodule

// File: rtl/ieee754_op_front.sv
// ieee754_op_front: request FIFO, special-operand bypass and FP-unit sequencing
module ieee754_op_front
  import ieee754_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ieee754_op_front_if.slave  io,
  output logic [31:0]        fu_a,
  output logic [31:0]        fu_b,
  output logic [1:0]         fu_op,
  input  logic [31:0]        fu_result,
  output logic               busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e        state;
  req_t          q [FIFO_DEPTH];
  req_t          h;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt_q;
  logic [3:0]    cnt;
  logic          push, pop, empty;
  cls_e          ca, cb;
  logic [31:0]   ya, yb, res;
  logic          da, db, sa, sb, za, zb, spec, div, byp;
  logic [3:0]    flg;
  assign empty = cnt_q == '0;
  assign io.in_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign push = io.in_valid && io.in_ready;
  assign pop = !empty && (state == IDLE || (state == RESP && io.out_ready));
  assign busy = state != IDLE || !empty;
  assign h = q[rp];
  ieee754_classify u_cls_a (.x(h.a), .cls(ca), .y(ya), .den(da));
  ieee754_classify u_cls_b (.x(h.b), .cls(cb), .y(yb), .den(db));
  assign sa = ya[31];
  assign sb = yb[31];
  assign za = ca == CLS_ZERO;
  assign zb = cb == CLS_ZERO;
  assign spec = ca == CLS_NAN || ca == CLS_INF || cb == CLS_NAN || cb == CLS_INF;
  assign div = h.op == OP_DIV;
  // every non-normal pair is resolved locally, so bypass is simply "any special or zero operand"
  assign byp = spec || za || zb;
  // canned result and flags for the head entry, first matching rule wins
  always_comb begin
    res = spec ? QNAN :
          div ? (za && zb ? QNAN : zb ? {sa ^ sb, EXP_MAX, 23'b0} : {sa ^ sb, 31'b0}) :
          h.op == OP_MUL ? {sa ^ sb, 31'b0} :
          h.op == OP_ADD ? (za ? (zb ? 32'h0 : yb) : ya) :
          (za ? (zb ? 32'h0 : {~sb, yb[30:0]}) : ya);
    flg = '0;
    flg[FLG_INV] = spec || (div && za && zb);
    flg[FLG_DBZ] = div && zb && !za && !spec;
    flg[FLG_BYP] = byp;
    flg[FLG_DEN] = da || db;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  // FIFO storage, contents need no reset since occupancy gates every read
  always_ff @(posedge clk)
    if (push) q[wp] <= '{a: io.in_a, b: io.in_b, op: io.in_op};
  // sequencer: pop and dispatch, wait for the unit to settle, hold the response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      fu_a <= '0;
      fu_b <= '0;
      fu_op <= '0;
      io.out_valid <= 1'b0;
      io.out_result <= '0;
      io.out_flags <= '0;
    end else if (state == WAIT) begin
      if (cnt == '0) begin
        io.out_result <= fu_result;
        io.out_valid <= 1'b1;
        state <= RESP;
      end else cnt <= cnt - 1'b1;
    end else if (pop) begin
      fu_a <= ya;
      fu_b <= yb;
      fu_op <= h.op;
      io.out_flags <= flg;
      io.out_valid <= byp;
      cnt <= 4'(LATENCY - 1);
      if (byp) io.out_result <= res;
      state <= byp ? RESP : WAIT;
    end else if (state == IDLE || io.out_ready) begin
      io.out_valid <= 1'b0;
      state <= IDLE;
    end
endmodule
